// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the slice-serial register file.
package regfile_pkg;

    localparam int unsigned DEF_NUM_REGS   = 16;
    localparam int unsigned DEF_SLICE_W    = 8;
    localparam int unsigned DEF_NUM_SLICES = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sweep: walks every storage entry once, then hands over to RUN.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int unsigned NENT = DEF_NUM_REGS * DEF_NUM_SLICES,
    parameter int unsigned AW   = $clog2(NENT)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    state_e        state;
    logic [AW-1:0] cnt;

    // Counter holds on the last entry so it never wraps inside CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else if (state == CLEAR) begin
            if (cnt == AW'(NENT - 1)) begin
                state <= RUN;
            end else begin
                cnt <= cnt + AW'(1);
            end
        end
    end

    assign busy     = (state == CLEAR);
    assign clr_we   = (state == CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/sliced_regfile.sv
// Slice-serial register file: two registered read ports, one write port with
// same-cycle bypass, optional hard-wired zero register and a clear sweep after reset.
module sliced_regfile
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS   = DEF_NUM_REGS,
    parameter int unsigned SLICE_W    = DEF_SLICE_W,
    parameter int unsigned NUM_SLICES = DEF_NUM_SLICES,
    parameter bit          ZERO_REG   = 1'b1,
    localparam int unsigned RW   = $clog2(NUM_REGS),
    localparam int unsigned PW   = $clog2(NUM_SLICES),
    localparam int unsigned NENT = NUM_REGS * NUM_SLICES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PW-1:0]      phase,
    input  logic [RW-1:0]      rs1,
    input  logic [RW-1:0]      rs2,
    input  logic [RW-1:0]      rd,
    input  logic               rd_we,
    input  logic [SLICE_W-1:0] rd_dat,
    output logic [SLICE_W-1:0] rs1_dat,
    output logic [SLICE_W-1:0] rs2_dat,
    output logic               busy
);

    localparam int unsigned AW = RW + PW;

    logic               clr_we;
    logic [AW-1:0]      clr_addr;
    logic [SLICE_W-1:0] mem [NENT];

    logic               user_we_c;
    logic               mem_we_c;
    logic [AW-1:0]      mem_addr_c;
    logic [SLICE_W-1:0] mem_wdat_c;
    logic [SLICE_W-1:0] rs1_nxt_c;
    logic [SLICE_W-1:0] rs2_nxt_c;

    regfile_clear_seq #(
        .NENT (NENT),
        .AW   (AW)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Sweep owns the write port while busy; reset blocks every write.
    always_comb begin
        user_we_c  = rd_we && !busy && !(ZERO_REG && (rd == '0));
        mem_we_c   = !rst && (clr_we || user_we_c);
        mem_addr_c = clr_we ? clr_addr : {rd, phase};
        mem_wdat_c = clr_we ? '0 : rd_dat;
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_addr_c] <= mem_wdat_c;
        end
    end

    // Zero register overrides the bypass, which overrides the stored slice.
    always_comb begin
        rs1_nxt_c = mem[{rs1, phase}];
        rs2_nxt_c = mem[{rs2, phase}];
        if (user_we_c && (rd == rs1)) begin
            rs1_nxt_c = rd_dat;
        end
        if (user_we_c && (rd == rs2)) begin
            rs2_nxt_c = rd_dat;
        end
        if (ZERO_REG && (rs1 == '0)) begin
            rs1_nxt_c = '0;
        end
        if (ZERO_REG && (rs2 == '0)) begin
            rs2_nxt_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || busy) begin
            rs1_dat <= '0;
            rs2_dat <= '0;
        end else begin
            rs1_dat <= rs1_nxt_c;
            rs2_dat <= rs2_nxt_c;
        end
    end

endmodule

// File: tb/tb_sliced_regfile.sv
// Self-checking bench: default instance with and without the zero register,
// plus a resized instance, all compared against an array-based reference model.
module tb_sliced_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rd_we;
    logic [1:0] phase;
    logic [3:0] rs1, rs2, rd;
    logic [7:0] rd_dat;
    logic [7:0] a_rs1, a_rs2, b_rs1, b_rs2;
    logic       a_busy, b_busy;

    logic       c_rst, c_rd_we;
    logic [2:0] c_phase;
    logic [4:0] c_rs1, c_rs2, c_rd;
    logic [3:0] c_rd_dat, c_rs1_dat, c_rs2_dat;
    logic       c_busy;

    sliced_regfile #(.ZERO_REG(1'b1)) u_a (
        .clk(clk), .rst(rst), .phase(phase), .rs1(rs1), .rs2(rs2), .rd(rd),
        .rd_we(rd_we), .rd_dat(rd_dat), .rs1_dat(a_rs1), .rs2_dat(a_rs2), .busy(a_busy)
    );

    sliced_regfile #(.ZERO_REG(1'b0)) u_b (
        .clk(clk), .rst(rst), .phase(phase), .rs1(rs1), .rs2(rs2), .rd(rd),
        .rd_we(rd_we), .rd_dat(rd_dat), .rs1_dat(b_rs1), .rs2_dat(b_rs2), .busy(b_busy)
    );

    sliced_regfile #(.NUM_REGS(32), .SLICE_W(4), .NUM_SLICES(8), .ZERO_REG(1'b1)) u_c (
        .clk(clk), .rst(c_rst), .phase(c_phase), .rs1(c_rs1), .rs2(c_rs2), .rd(c_rd),
        .rd_we(c_rd_we), .rd_dat(c_rd_dat), .rs1_dat(c_rs1_dat), .rs2_dat(c_rs2_dat),
        .busy(c_busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain 2-D arrays plus a count of remaining sweep cycles.
    int unsigned left_ab = 0;
    int unsigned left_c  = 0;
    logic [7:0]  m_a [16][4];
    logic [7:0]  m_b [16][4];
    logic [3:0]  m_c [32][8];
    logic [7:0]  e_a1, e_a2, e_b1, e_b2;
    logic [3:0]  e_c1, e_c2;
    logic        e_busy_ab, e_busy_c;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_ab();
        if (rst) begin
            left_ab = 64;
            {e_a1, e_a2, e_b1, e_b2} = '0;
            foreach (m_a[r, p]) begin
                m_a[r][p] = 8'h00;
                m_b[r][p] = 8'h00;
            end
        end else if (left_ab != 0) begin
            left_ab--;
            {e_a1, e_a2, e_b1, e_b2} = '0;
        end else begin
            e_a1 = (rs1 == 0) ? 8'h00 : (rd_we && rd == rs1) ? rd_dat : m_a[rs1][phase];
            e_a2 = (rs2 == 0) ? 8'h00 : (rd_we && rd == rs2) ? rd_dat : m_a[rs2][phase];
            e_b1 = (rd_we && rd == rs1) ? rd_dat : m_b[rs1][phase];
            e_b2 = (rd_we && rd == rs2) ? rd_dat : m_b[rs2][phase];
            if (rd_we && rd != 0) m_a[rd][phase] = rd_dat;
            if (rd_we) m_b[rd][phase] = rd_dat;
        end
        e_busy_ab = (left_ab != 0);
    endtask

    task automatic model_c();
        if (c_rst) begin
            left_c = 256;
            {e_c1, e_c2} = '0;
            foreach (m_c[r, p]) m_c[r][p] = 4'h0;
        end else if (left_c != 0) begin
            left_c--;
            {e_c1, e_c2} = '0;
        end else begin
            e_c1 = (c_rs1 == 0) ? 4'h0 : (c_rd_we && c_rd == c_rs1) ? c_rd_dat : m_c[c_rs1][c_phase];
            e_c2 = (c_rs2 == 0) ? 4'h0 : (c_rd_we && c_rd == c_rs2) ? c_rd_dat : m_c[c_rs2][c_phase];
            if (c_rd_we && c_rd != 0) m_c[c_rd][c_phase] = c_rd_dat;
        end
        e_busy_c = (left_c != 0);
    endtask

    task automatic tick();
        model_ab();
        model_c();
        @(posedge clk);
        #1;
        check("a_busy", 32'(a_busy), 32'(e_busy_ab));
        check("b_busy", 32'(b_busy), 32'(e_busy_ab));
        check("a_rs1", 32'(a_rs1), 32'(e_a1));
        check("a_rs2", 32'(a_rs2), 32'(e_a2));
        check("b_rs1", 32'(b_rs1), 32'(e_b1));
        check("b_rs2", 32'(b_rs2), 32'(e_b2));
        check("c_busy", 32'(c_busy), 32'(e_busy_c));
        check("c_rs1", 32'(c_rs1_dat), 32'(e_c1));
        check("c_rs2", 32'(c_rs2_dat), 32'(e_c2));
    endtask

    // Runs until both sweeps are over, poking writes at any instance still busy.
    task automatic sweep_len(output int n_ab, output int n_c);
        n_ab = 0;
        n_c  = 0;
        for (int i = 0; i < 300; i++) begin
            rd_we   = a_busy ? 1'($urandom) : 1'b0;
            rd      = 4'($urandom);
            phase   = 2'($urandom);
            rd_dat  = 8'($urandom);
            rs1     = 4'($urandom);
            rs2     = 4'($urandom);
            c_rd_we = c_busy ? 1'($urandom) : 1'b0;
            c_rd    = 5'($urandom);
            c_phase = 3'($urandom);
            c_rd_dat = 4'($urandom);
            tick();
            if (!a_busy && n_ab == 0) n_ab = i + 1;
            if (!c_busy && n_c == 0) n_c = i + 1;
            if (!a_busy && !c_busy) break;
        end
        rd_we   = 1'b0;
        c_rd_we = 1'b0;
    endtask

    logic [7:0] basic_exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int n_ab, n_c;

    initial begin
        rst = 1'b1; c_rst = 1'b1;
        rd_we = 1'b0; phase = '0; rs1 = '0; rs2 = '0; rd = '0; rd_dat = '0;
        c_rd_we = 1'b0; c_phase = '0; c_rs1 = '0; c_rs2 = '0; c_rd = '0; c_rd_dat = '0;

        // Reset and first sweep, with stray writes during busy.
        tick();
        tick();
        check("reset_busy", 32'(a_busy), 32'd1);
        check("reset_rs1", 32'(a_rs1), 32'd0);
        rst = 1'b0; c_rst = 1'b0;
        sweep_len(n_ab, n_c);
        check("busy_len_default", 32'(n_ab), 32'd64);
        check("busy_len_param", 32'(n_c), 32'd256);

        // Every entry reads zero after the sweep.
        for (int r = 0; r < 16; r++) begin
            for (int p = 0; p < 4; p++) begin
                rs1 = 4'(r); rs2 = 4'(15 - r); phase = 2'(p);
                tick();
                check("clear_b", 32'(b_rs1), 32'd0);
            end
        end

        // Basic write then read of x5.
        rd = 4'd5; rd_we = 1'b1; rs1 = 4'd1; rs2 = 4'd2;
        for (int p = 0; p < 4; p++) begin
            phase = 2'(p); rd_dat = basic_exp[p];
            tick();
        end
        rd_we = 1'b0; rs1 = 4'd5;
        for (int p = 0; p < 4; p++) begin
            phase = 2'(p);
            tick();
            check("basic_read", 32'(a_rs1), 32'(basic_exp[p]));
        end

        // Bypass on both ports.
        rd = 4'd7; phase = 2'd2; rd_dat = 8'hAA; rd_we = 1'b1; rs1 = 4'd0; rs2 = 4'd0;
        tick();
        rd_dat = 8'h5C; rs1 = 4'd7; rs2 = 4'd7;
        tick();
        check("bypass_rs1", 32'(a_rs1), 32'h5C);
        check("bypass_rs2", 32'(a_rs2), 32'h5C);
        rd_we = 1'b0;
        tick();
        check("bypass_after", 32'(a_rs1), 32'h5C);

        // Zero register, including same-cycle bypass.
        rd = 4'd0; rd_dat = 8'hFF; rd_we = 1'b1; rs1 = 4'd0; rs2 = 4'd0;
        for (int p = 0; p < 4; p++) begin
            phase = 2'(p);
            tick();
            check("zero_bypass_a", 32'(a_rs1), 32'h00);
            check("zero_bypass_b", 32'(b_rs2), 32'hFF);
        end
        rd_we = 1'b0;
        for (int p = 0; p < 4; p++) begin
            phase = 2'(p);
            tick();
            check("zero_read_a", 32'(a_rs2), 32'h00);
            check("zero_read_b", 32'(b_rs1), 32'hFF);
        end

        // Random traffic, including non-advancing phases.
        for (int i = 0; i < 200; i++) begin
            rd_we  = 1'($urandom);
            rd     = 4'($urandom_range(0, 7));
            rs1    = 4'($urandom_range(0, 7));
            rs2    = 4'($urandom_range(0, 7));
            phase  = ($urandom_range(0, 3) == 0) ? phase : 2'($urandom);
            rd_dat = 8'($urandom);
            tick();
        end
        rd_we = 1'b0;

        // Reset in RUN (with a competing write) and again mid-sweep.
        rd = 4'd3; phase = 2'd1; rd_dat = 8'h9E; rd_we = 1'b1; rs1 = 4'd0; rs2 = 4'd0;
        tick();
        rd_we = 1'b0; rs1 = 4'd3;
        tick();
        check("x3_written", 32'(a_rs1), 32'h9E);
        rst = 1'b1; rd_we = 1'b1; rd_dat = 8'h55;
        tick();
        rst = 1'b0; rd_we = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("midsweep_busy", 32'(a_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep_len(n_ab, n_c);
        check("busy_len_restart", 32'(n_ab), 32'd64);
        rd = 4'd3; phase = 2'd1; rs1 = 4'd3; rs2 = 4'd3;
        tick();
        check("x3_cleared", 32'(a_rs1), 32'h00);
        check("x3_cleared_b", 32'(b_rs2), 32'h00);

        // Resized instance: single slice written, neighbours stay zero.
        c_rd = 5'd31; c_phase = 3'd7; c_rd_dat = 4'hC; c_rd_we = 1'b1;
        tick();
        c_rd_we = 1'b0; c_rs1 = 5'd31; c_rs2 = 5'd31;
        for (int p = 0; p < 8; p++) begin
            c_phase = 3'(p);
            tick();
            check("param_x31", 32'(c_rs1_dat), (p == 7) ? 32'hC : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sliced_regfile.md
Name: sliced_regfile

Overview:
- Parametrised, slice-serial general-purpose register file for the bit/byte-serial core.
- Each register is NUM_SLICES slices of SLICE_W bits. The phase input selects which slice is read and written this cycle.
- New relative to the previous generation:
  - all sizes are parameters;
  - an explicit write enable;
  - same-cycle write-to-read bypass;
  - a single-edge registered read;
  - a hardware clear sweep after reset.
- Sits between the decoder (register indices) and the slice-serial ALU (operand and result slices).

Parameters:
- NUM_REGS, 16: number of architectural registers; power of two, at least 2.
- SLICE_W, 8: bits per slice.
- NUM_SLICES, 4: slices per register; power of two, at least 2.
- ZERO_REG, 1: 1 makes register 0 read as zero and ignore writes; 0 makes register 0 an ordinary register.
- Derived (localparams, not overridable):
  - RW = log2(NUM_REGS);
  - PW = log2(NUM_SLICES);
  - NENT = NUM_REGS*NUM_SLICES.

Ports:
- clk, input, 1: clock. All logic is on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- phase, input, PW: slice index for both the read and the write this cycle.
- rs1, input, RW: read port 1 register index.
- rs2, input, RW: read port 2 register index.
- rd, input, RW: write register index.
- rd_we, input, 1: write enable.
- rd_dat, input, SLICE_W: write slice data.
- rs1_dat, output, SLICE_W: registered read data, port 1.
- rs2_dat, output, SLICE_W: registered read data, port 2.
- busy, output, 1: high while the clear sweep runs.

Behaviour:
- Storage: NENT entries of SLICE_W bits, addressed by {reg, phase}.
- Reset:
  - While rst is high at a clock edge: rs1_dat=0, rs2_dat=0, busy=1, sweep counter=0, state=CLEAR.
  - A reset asserted mid-sweep or mid-run restarts the sweep from entry 0.
- State machine has two states:
  - CLEAR:
    - Each cycle, write 0 to entry cnt and increment cnt.
    - rd_we is ignored and rs*_dat are held at 0.
    - When cnt reaches NENT-1, that entry is written, then the next state is RUN and busy falls. The sweep takes exactly NENT cycles after rst deasserts.
    - With ZERO_REG=1 the sweep still covers register 0 (harmless). The counter never wraps inside CLEAR.
  - RUN:
    - Stays in RUN until rst.
- Write (RUN only):
  - If rd_we=1 and !(ZERO_REG && rd==0), then mem[rd][phase] <= rd_dat at the edge.
- Read (RUN only), latency 1 cycle:
  - At each edge, rsN_dat <= value of mem[rsN][phase] as of before the edge.
  - Exception 1, bypass: if rd_we=1, rd==rsN, and the write is not suppressed, then rsN_dat <= rd_dat.
  - Exception 2, zero register: if ZERO_REG && rsN==0, then rsN_dat <= 0, regardless of the bypass.
  - rs1==rs2 is legal; both ports return identical data.
- Write and read on different slices never interact: the phase is shared, so bypass applies only to the same slice by construction.
- A phase that does not advance is legal; the same slice can be re-read or re-written on consecutive cycles.
- No X on outputs after reset. Every entry is defined once busy falls.
- Simultaneous events:
  - rst with rd_we: rst wins; no write occurs.
  - Last sweep cycle with rd_we: the write is ignored (busy is still 1 during that cycle).

Decomposition:
- Shared package regfile_pkg holds:
  - the default constants for NUM_REGS, SLICE_W and NUM_SLICES;
  - the state encoding, CLEAR=1'b0 and RUN=1'b1.
- One sub-module, regfile_clear_seq: the sweep counter and state FSM. It outputs busy, clr_we and clr_addr[RW+PW-1:0].
- The top-level block muxes clr_* against the user write path and holds the array and read/bypass logic.

Test Plan:
- Reset sweep: rst high 2 cycles, then low.
  - busy must stay 1 for exactly 64 cycles (defaults), then drop.
  - Every reg and phase then reads 0x00.
  - rd_we pulses during busy must leave no trace.
- Basic write/read: write x5 slices 0..3 with 0x11, 0x22, 0x33, 0x44 over phases 0..3; then read rs1=5 over phases 0..3.
  - rs1_dat must be 0x11, 0x22, 0x33, 0x44, each 1 cycle after its phase.
- Bypass: with x7 slice 2 = 0xAA, in one cycle set phase=2, rd=7, rd_we=1, rd_dat=0x5C, rs1=7, rs2=7.
  - Next cycle rs1_dat=rs2_dat=0x5C. The following read of x7 slice 2 also gives 0x5C.
- Zero register:
  - ZERO_REG=1: write 0xFF to x0, all phases; reads and bypass of x0 return 0x00.
  - ZERO_REG=0 instance: x0 returns 0xFF.
- Reset mid-operation: write x3 slice 1 = 0x9E, then assert rst during RUN, and again at sweep cycle 30.
  - Each reset restarts the sweep at entry 0, giving a full 64-cycle busy.
  - Afterwards x3 slice 1 reads 0x00.
- Parameter sweep: NUM_REGS=32, SLICE_W=4, NUM_SLICES=8.
  - busy lasts 256 cycles.
  - Write x31 phase 7 = 0xC, with neighbouring phases left at 0; read back gives 0xC only at phase 7.
